// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the D-stage hazard scheduler: mult/div latencies,
// Tuse/Tnew encodings, decoder opcode/func constants and the hazard compare helper.
package hazard_scheduler_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned T_W             = 2;

    // Tuse/Tnew encodings: cycles until a value is consumed/produced
    localparam logic [T_W-1:0] T_0 = 2'd0;
    localparam logic [T_W-1:0] T_1 = 2'd1;
    localparam logic [T_W-1:0] T_2 = 2'd2;

    // Opcode / func constants shared with the stage decoders
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Write-back view of one downstream pipeline stage
    typedef struct packed {
        logic [REG_W-1:0] wreg;
        logic             en;
        logic [T_W-1:0]   tnew;
    } wr_stage_t;

    // Source operand must wait if a producer will not have its value in time
    function automatic logic src_hazard(
        input logic [REG_W-1:0] src,
        input logic             use_src,
        input logic [T_W-1:0]   tuse,
        input wr_stage_t        e,
        input wr_stage_t        m
    );
        logic hit_e;
        logic hit_m;
        hit_e = e.en && (e.wreg == src) && (e.tnew > tuse);
        hit_m = m.en && (m.wreg == src) && (m.tnew > tuse);
        return use_src && (src != '0) && (hit_e || hit_m);
    endfunction

endpackage

// File: rtl/hazard_scheduler_md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit: loads on start while idle,
// decrements every cycle while busy, pulses md_done when it reaches zero.
module md_busy_counter
    import hazard_scheduler_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o,
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] load_val;
    md_state_e        state;

    assign state    = (cnt_q != '0) ? MD_BUSY : MD_IDLE;
    assign load_val = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // State register: count, busy and done flags, aborted by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next count: load when idle, decrement when busy, reload on same-edge finish+start
    always_comb begin
        cnt_d = cnt_q;
        unique case (state)
            MD_IDLE: begin
                if (start_i) cnt_d = load_val;
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if ((cnt_q == CNT_W'(1)) && start_i) cnt_d = load_val;
            end
            default: cnt_d = '0;
        endcase
    end

    // Next outputs: busy mirrors the next count, done marks the 1 -> 0 step
    always_comb begin
        busy_d = (cnt_d != '0);
        done_d = (state == MD_BUSY) && (cnt_q == CNT_W'(1));
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/hazard_scheduler.sv
// D-stage hazard controller: register RAW stall/flush against E/M producers
// plus mult/div sequencing. Optional stall statistics under HAZARD_STATS_EN.
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic             use_rs_D,
    input  logic             use_rt_D,
    input  logic [T_W-1:0]   Tuse_rs_D,
    input  logic [T_W-1:0]   Tuse_rt_D,
    input  logic [REG_W-1:0] WriteReg_E,
    input  logic             En_Write_E,
    input  logic [T_W-1:0]   Tnew_E,
    input  logic [REG_W-1:0] WriteReg_M,
    input  logic             En_Write_M,
    input  logic [T_W-1:0]   Tnew_M,
    input  logic             md_use_D,
    input  logic             md_start_E,
    input  logic             md_is_div_E,
    output logic             stall,
    output logic             flush_E,
    output logic             md_busy,
    output logic             md_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      md_stall_cycles
`endif
);

    wr_stage_t e_stage;
    wr_stage_t m_stage;
    logic      hz_rs;
    logic      hz_rt;
    logic      md_stall;

    assign e_stage = '{wreg: WriteReg_E, en: En_Write_E, tnew: Tnew_E};
    assign m_stage = '{wreg: WriteReg_M, en: En_Write_M, tnew: Tnew_M};

    // Register and mult/div hazards; a stalled D instruction becomes a bubble in E
    always_comb begin
        hz_rs    = src_hazard(rs_D, use_rs_D, Tuse_rs_D, e_stage, m_stage);
        hz_rt    = src_hazard(rt_D, use_rt_D, Tuse_rt_D, e_stage, m_stage);
        md_stall = md_use_D && (md_busy || md_start_E);
        stall    = hz_rs || hz_rt || md_stall;
        flush_E  = stall;
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_cnt (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start_E),
        .is_div_i (md_is_div_E),
        .busy_o   (md_busy),
        .done_o   (md_done)
    );

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] md_stall_cycles_q;

    // Saturating stall-cycle counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q    <= '0;
            md_stall_cycles_q <= '0;
        end else begin
            if (stall && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (md_stall && (md_stall_cycles_q != '1))
                md_stall_cycles_q <= md_stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles    = stall_cycles_q;
    assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Sits beside the D stage.
- Compares the D-stage source registers and their Tuse against the E/M-stage WriteReg/En_Write/Tnew from the per-stage instruction decoders, and raises stall/flush.
- Also sequences the multi-cycle mult/div unit: owns its busy counter and blocks HI/LO-touching instructions until it finishes.

Parameters:
- MULT_CYCLES, 5, E-stage busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs_D  in  5  D-stage rs field.
- rt_D  in  5  D-stage rt field.
- use_rs_D  in  1  D instruction reads rs.
- use_rt_D  in  1  D instruction reads rt.
- Tuse_rs_D  in  2  cycles until rs is consumed.
- Tuse_rt_D  in  2  cycles until rt is consumed.
- WriteReg_E  in  5  E-stage destination register.
- En_Write_E  in  1  E-stage write enable.
- Tnew_E  in  2  E-stage Tnew.
- WriteReg_M  in  5  M-stage destination register.
- En_Write_M  in  1  M-stage write enable.
- Tnew_M  in  2  M-stage Tnew.
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_E  in  1  E-stage mult/div entering the unit this cycle.
- md_is_div_E  in  1  1 = div/divu, 0 = mult/multu.
- stall  out  1  freeze PC and IF/ID.
- flush_E  out  1  insert bubble into ID/EX.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse when the result is ready.

Behaviour:
- Register hazard (combinational), evaluated separately for rs and rt:
  - hz_x = use_x && x_D != 0 && ((En_Write_E && WriteReg_E == x_D && Tnew_E > Tuse_x_D) || (En_Write_M && WriteReg_M == x_D && Tnew_M > Tuse_x_D)).
  - Comparisons are unsigned 2-bit.
  - $0 never stalls.
  - Equal Tnew and Tuse means no stall; forwarding covers it.
- md hazard (combinational): md_stall = md_use_D && (md_busy || md_start_E).
- Outputs: stall = hz_rs | hz_rt | md_stall. flush_E = stall, same cycle.
- Busy counter cnt (CNT_W bits), states IDLE (cnt == 0) and BUSY (cnt != 0). md_busy = (cnt != 0), registered.
- IDLE -> BUSY: on a clk edge with md_start_E = 1, load cnt with DIV_CYCLES if md_is_div_E else MULT_CYCLES.
- BUSY: cnt decrements every cycle and is never stalled or frozen.
- BUSY -> IDLE: cnt reaches 0. On the same edge md_done is set for exactly one cycle.
- md_start_E while BUSY: ignored. No reload, count unaffected. The design guarantees this cannot occur because md_stall holds md instructions in D.
- Same-edge completion and start: if cnt goes 1 -> 0 and md_start_E = 1 on the same edge, cnt reloads. md_done still pulses.
- Reset (asynchronous, any time including mid-operation):
  - cnt = 0, md_busy = 0, md_done = 0; an in-flight operation is aborted.
  - stall/flush_E then follow their combinational inputs.
- Latency: a mult started at edge k raises md_busy after edge k. md_done is high for the cycle after edge k+MULT_CYCLES, and md_busy is low from that edge on.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds two outputs:
  - stall_cycles [31:0]: increments every cycle stall = 1.
  - md_stall_cycles [31:0]: increments when md_stall = 1.
- Both counters reset to 0, saturate at 32'hFFFFFFFF, and are read-only.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared define file holds:
  - the MULT_CYCLES/DIV_CYCLES defaults;
  - Tuse/Tnew encodings (0, 1, 2);
  - the opcode/func constants already used by the stage decoders.
- One natural sub-module, md_busy_counter: load/decrement counter producing md_busy and md_done. Hazard compare logic stays at the top level.

Test Plan:
- Load-use: E has lw $8 with Tnew_E = 2; D has addu using rs = $8, Tuse = 1 -> stall = flush_E = 1 for one cycle. Next cycle (M, Tnew_M = 1) -> stall = 0.
- $0 and no-write cases:
  - WriteReg_E = 0, rs_D = 0, Tnew_E = 2 -> stall = 0.
  - En_Write_E = 0 with a matching register -> stall = 0.
- Mult sequencing: md_start_E = 1, md_is_div_E = 0 -> md_busy high for 5 cycles and md_done pulses once. mflo in D during those cycles -> stall = 1 until md_busy falls.
- Div: start with md_is_div_E = 1 -> md_busy high for 10 cycles. A second md_start_E pulse at cycle 3 -> count unaffected, done still at cycle 10.
- Async reset mid-div (cycle 4) -> md_busy = md_done = 0 immediately, without waiting for a clock edge. A new mult afterwards runs the full 5 cycles.
- HAZARD_STATS_EN: run 3 load-use stalls and one 5-cycle mflo wait -> stall_cycles = 8, md_stall_cycles = 5.
